// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: per-channel synchroniser, lock-out hold timer,
// one-cycle rise/fall strobes and a one-shot long-press detector.
module debounce_multi #(
    parameter int unsigned N           = 4,
    parameter int unsigned HOLD_CYCLES = 5000000,
    parameter int unsigned LONG_CYCLES = 50000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] b,
    output logic [N-1:0] d,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press,
    output logic [N-1:0] busy
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned LW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    typedef enum logic {
        READY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  s;

    state_e        state_q [N];
    state_e        state_d [N];
    logic [HW-1:0] hold_q  [N];
    logic [HW-1:0] hold_d  [N];
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [N-1:0]  busy_q, busy_d;

    // Input synchroniser chain; s is b delayed by SYNC_STAGES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= b;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel READY/HOLD state and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                state_q[i] <= READY;
                hold_q[i]  <= '0;
            end
            d_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            d_q    <= d_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        d_d     = d_q;
        rise_d  = '0;
        fall_d  = '0;
        busy_d  = busy_q;
        for (int i = 0; i < int'(N); i++) begin
            case (state_q[i])
                READY: begin
                    if (s[i] != d_q[i]) begin
                        d_d[i]     = s[i];
                        rise_d[i]  = s[i];
                        fall_d[i]  = ~s[i];
                        state_d[i] = HOLD;
                        hold_d[i]  = '0;
                        busy_d[i]  = 1'b1;
                    end
                end
                HOLD: begin
                    // s is ignored until the lock-out has run its full length
                    if (hold_q[i] == HW'(HOLD_CYCLES - 1)) begin
                        state_d[i] = READY;
                        hold_d[i]  = '0;
                        busy_d[i]  = 1'b0;
                    end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                    end
                end
                default: begin
                    state_d[i] = READY;
                end
            endcase
        end
    end

    generate
        if (LONG_CYCLES > 0) begin : g_long
            logic [LW-1:0] long_q [N];
            logic [LW-1:0] long_d [N];
            logic [N-1:0]  lp_q, lp_d;

            // Counter stops at LONG_CYCLES so the strobe fires once per press
            always_comb begin
                long_d = long_q;
                lp_d   = '0;
                for (int i = 0; i < int'(N); i++) begin
                    if (!d_q[i]) begin
                        long_d[i] = '0;
                    end else begin
                        if (long_q[i] == LW'(LONG_CYCLES - 1)) begin
                            lp_d[i] = 1'b1;
                        end
                        if (long_q[i] == LW'(LONG_CYCLES)) begin
                            long_d[i] = long_q[i];
                        end else begin
                            long_d[i] = long_q[i] + LW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(N); i++) begin
                        long_q[i] <= '0;
                    end
                    lp_q <= '0;
                end else begin
                    for (int i = 0; i < int'(N); i++) begin
                        long_q[i] <= long_d[i];
                    end
                    lp_q <= lp_d;
                end
            end

            assign long_press = lp_q;
        end else begin : g_no_long
            assign long_press = '0;
        end
    endgenerate

    assign d    = d_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected strobe events by cycle,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_debounce_multi;

    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned LONG = 32;
    localparam int unsigned SS   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] b   = 4'hF;
    logic [N-1:0] d, rise, fall, long_press, busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int       cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lp;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    debounce_multi #(
        .N          (N),
        .HOLD_CYCLES(HOLD),
        .LONG_CYCLES(LONG),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b         (b),
        .d         (d),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Insert in cycle order; events on the same cycle are merged
    function automatic void push_exp(input int c, input logic [3:0] r,
                                     input logic [3:0] f, input logic [3:0] l);
        ev_t e;
        int  idx;
        bit  merged;
        idx    = exp_q.size();
        merged = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                e = exp_q[i];
                e.rise = e.rise | r;
                e.fall = e.fall | f;
                e.lp   = e.lp | l;
                exp_q[i] = e;
                merged = 1'b1;
            end else if (exp_q[i].cyc > c && idx == exp_q.size()) begin
                idx = i;
            end
        end
        if (!merged) begin
            e.cyc  = c;
            e.rise = r;
            e.fall = f;
            e.lp   = l;
            exp_q.insert(idx, e);
        end
    endfunction

    // Monitor: any strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d got=none expected rise=%h fall=%h lp=%h",
                         exp_q[0].cyc, exp_q[0].rise, exp_q[0].fall, exp_q[0].lp);
                void'(exp_q.pop_front());
            end
            if ((rise | fall | long_press) != 4'h0) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    mon_e = exp_q.pop_front();
                    check("ev_rise", 32'(rise), 32'(mon_e.rise));
                    check("ev_fall", 32'(fall), 32'(mon_e.fall));
                    check("ev_long_press", 32'(long_press), 32'(mon_e.lp));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got rise=%h fall=%h lp=%h expected none",
                             cyc, rise, fall, long_press);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        int t;
        int n;
        int bad;

        // Reset with all buttons pressed
        rst = 1'b1;
        b   = 4'hF;
        repeat (3) begin
            tick();
            check("reset_d", 32'(d), 32'h0);
            check("reset_strobes", 32'(rise | fall | long_press), 32'h0);
            check("reset_busy", 32'(busy), 32'h0);
        end
        rst = 1'b0;
        t = cyc;
        push_exp(t + 3, 4'hF, 4'h0, 4'h0);
        push_exp(t + 35, 4'h0, 4'h0, 4'hF);
        tick();
        check("post_reset_d", 32'(d), 32'h0);
        check("post_reset_busy", 32'(busy), 32'h0);
        wait_until(t + 3);
        check("t1_d", 32'(d), 32'hF);
        check("t1_busy", 32'(busy), 32'hF);
        wait_until(t + 37);

        // Bring ch0 low so the bounce test starts from 0
        t = cyc;
        b[0] = 1'b0;
        push_exp(t + 3, 4'h0, 4'h1, 4'h0);
        wait_until(t + 12);

        // Bounce rejection on ch0
        t = cyc;
        b[0] = 1'b1;
        push_exp(t + 3, 4'h1, 4'h0, 4'h0);
        push_exp(t + 35, 4'h0, 4'h0, 4'h1);
        n   = 0;
        bad = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 2 || k == 6) b[0] = 1'b0;
            else if (k == 4 || k == 8) b[0] = 1'b1;
            tick();
            if (busy[0]) n++;
            if (k >= 2 && d[0] !== 1'b1) bad++;
        end
        check("t2_busy_len", 32'(n), 32'd8);
        check("t2_d_stable", 32'(bad), 32'd0);

        // Hold boundary on ch1
        t = cyc;
        b[1] = 1'b0;
        push_exp(t + 3, 4'h0, 4'h2, 4'h0);
        wait_until(t + 11);
        b[1] = 1'b1;
        push_exp(t + 14, 4'h2, 4'h0, 4'h0);
        wait_until(t + 20);
        b[1] = 1'b0;
        push_exp(t + 23, 4'h0, 4'h2, 4'h0);
        tick();
        check("t3a_busy_last", 32'(busy[1]), 32'd1);
        tick();
        check("t3a_busy_clear", 32'(busy[1]), 32'd0);
        wait_until(t + 31);
        b[1] = 1'b1;
        push_exp(t + 34, 4'h2, 4'h0, 4'h0);
        wait_until(t + 39);
        b[1] = 1'b0;
        push_exp(t + 43, 4'h0, 4'h2, 4'h0);
        wait_until(t + 41);
        check("t3b_busy_last", 32'(busy[1]), 32'd1);
        tick();
        check("t3b_busy_clear", 32'(busy[1]), 32'd0);
        tick();
        check("t3b_d", 32'(d[1]), 32'd0);
        wait_until(t + 55);

        // Long press on ch2, then a short press
        t = cyc;
        b[2] = 1'b0;
        push_exp(t + 3, 4'h0, 4'h4, 4'h0);
        wait_until(t + 11);
        b[2] = 1'b1;
        push_exp(t + 14, 4'h4, 4'h0, 4'h0);
        push_exp(t + 46, 4'h0, 4'h0, 4'h4);
        wait_until(t + 61);
        b[2] = 1'b0;
        push_exp(t + 64, 4'h0, 4'h4, 4'h0);
        wait_until(t + 72);
        b[2] = 1'b1;
        push_exp(t + 75, 4'h4, 4'h0, 4'h0);
        wait_until(t + 92);
        b[2] = 1'b0;
        push_exp(t + 95, 4'h0, 4'h4, 4'h0);
        wait_until(t + 104);

        // Independence: ch0 rises while ch3 falls in the same cycle
        t = cyc;
        b[0] = 1'b0;
        push_exp(t + 3, 4'h0, 4'h1, 4'h0);
        wait_until(t + 12);
        b[0] = 1'b1;
        b[3] = 1'b0;
        push_exp(t + 15, 4'h1, 4'h8, 4'h0);
        wait_until(t + 15);
        check("t5_busy_start", 32'(busy), 32'h9);
        wait_until(t + 17);
        check("t5_d", 32'(d), 32'h1);
        wait_until(t + 22);
        check("t5_busy_last", 32'(busy), 32'h9);
        tick();
        check("t5_busy_clear", 32'(busy), 32'h0);
        b[0] = 1'b0;
        push_exp(t + 26, 4'h0, 4'h1, 4'h0);
        wait_until(t + 35);

        // Reset in the middle of ch0 hold and ch2 long count
        t = cyc;
        b[2] = 1'b1;
        push_exp(t + 3, 4'h4, 4'h0, 4'h0);
        wait_until(t + 16);
        b[0] = 1'b1;
        push_exp(t + 19, 4'h1, 4'h0, 4'h0);
        wait_until(t + 23);
        check("t6_pre_d", 32'(d), 32'h5);
        check("t6_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check("t6_rst_d", 32'(d), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_strobes", 32'(rise | fall | long_press), 32'h0);
        rst = 1'b0;
        push_exp(cyc + 3, 4'h5, 4'h0, 4'h0);
        push_exp(cyc + 35, 4'h0, 4'h0, 4'h5);
        tick();
        check("t6_post_d", 32'(d), 32'h0);
        wait_until(t + 27);
        check("t6_reassert_d", 32'(d), 32'h5);
        check("t6_reassert_busy", 32'(busy), 32'h5);
        wait_until(t + 64);
        check("t6_final_d", 32'(d), 32'h5);
        check("t6_final_busy", 32'(busy), 32'h0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
